sdram_arbiter: RTL and testbench

Schedules the single SDRAM command unit among three requesters: the periodic auto-refresh timer, the write-port burst request and the read-port burst request, the latter two issued by the SDRAM FIFO control logic. The block sits between the FIFO control logic and the SDRAM command/timing unit. It guarantees the refresh rate and alternates fairly between write and read bursts. It routes the command unit's data-phase strobe back to whichever port currently holds the grant.

---
 rtl/sdram_arbiter_pkg.sv | 21 ++
 rtl/sdram_arbiter_ref_timer.sv | 43 ++++
 rtl/sdram_arbiter.sv | 127 ++++++++++++
 tb/tb_sdram_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared encodings for the SDRAM arbiter and the command/timing unit.
package sdram_arbiter_pkg;

    localparam int unsigned CMD_W  = 2;
    localparam int unsigned OWED_W = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_NONE = 2'b00,
        CMD_REF  = 2'b01,
        CMD_WR   = 2'b10,
        CMD_RD   = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_ARB   = 2'b01,
        ST_ISSUE = 2'b10,
        ST_BUSY  = 2'b11
    } state_t;

endpackage

// File: rtl/sdram_arbiter_ref_timer.sv
// Refresh interval counter plus the saturating count of owed refreshes.
module sdram_ref_timer
    import sdram_arbiter_pkg::*;
#(
    parameter int unsigned REF_PERIOD = 781,
    parameter int unsigned MAX_PEND   = 4
) (
    input  logic              ref_clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              ref_served,
    output logic [OWED_W-1:0] ref_owed
);

    localparam int unsigned CNT_W = $clog2(REF_PERIOD + 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = init_done && (cnt == CNT_W'(REF_PERIOD - 1));

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (init_done) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

    // A wrap and a served refresh in the same cycle cancel out.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            ref_owed <= '0;
        end else if (wrap && !ref_served) begin
            if (ref_owed != OWED_W'(MAX_PEND)) begin
                ref_owed <= ref_owed + OWED_W'(1);
            end
        end else if (ref_served && !wrap && (ref_owed != '0)) begin
            ref_owed <= ref_owed - OWED_W'(1);
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates the SDRAM command unit between refresh, write bursts and read bursts.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int unsigned REF_PERIOD = 781,
    parameter int unsigned MAX_PEND   = 4,
    parameter int unsigned ADDR_W     = 21,
    parameter int unsigned LEN_W      = 9
) (
    input  logic              ref_clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              wr_ack,
    output logic              rd_ack,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [CMD_W-1:0]  cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              xfer_en,
    input  logic              cmd_done,
    output logic [OWED_W-1:0] ref_owed
);

    state_t            state;
    cmd_t              cmd_q;
    cmd_t              last_grant;
    cmd_t              grant;
    logic [ADDR_W-1:0] grant_addr;
    logic [LEN_W-1:0]  grant_len;
    logic              ref_served;

    assign ref_served = (state == ST_BUSY) && cmd_done && (cmd_q == CMD_REF);

    sdram_ref_timer #(
        .REF_PERIOD (REF_PERIOD),
        .MAX_PEND   (MAX_PEND)
    ) u_ref_timer (
        .ref_clk    (ref_clk),
        .rst        (rst),
        .init_done  (init_done),
        .ref_served (ref_served),
        .ref_owed   (ref_owed)
    );

    // Refresh first, then the write/read request that did not win last time.
    always_comb begin
        grant      = CMD_NONE;
        grant_addr = '0;
        grant_len  = '0;
        if (ref_owed != '0) begin
            grant = CMD_REF;
        end else if (wr_req && rd_req) begin
            grant = (last_grant == CMD_WR) ? CMD_RD : CMD_WR;
        end else if (wr_req) begin
            grant = CMD_WR;
        end else if (rd_req) begin
            grant = CMD_RD;
        end
        if (grant == CMD_WR) begin
            grant_addr = wr_addr;
            grant_len  = (wr_len == '0) ? LEN_W'(1) : wr_len;
        end else if (grant == CMD_RD) begin
            grant_addr = rd_addr;
            grant_len  = (rd_len == '0) ? LEN_W'(1) : rd_len;
        end
    end

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_INIT;
            cmd_valid  <= 1'b0;
            cmd_q      <= CMD_NONE;
            cmd_addr   <= '0;
            cmd_len    <= '0;
            last_grant <= CMD_RD;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_done) begin
                        state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (!init_done) begin
                        state <= ST_INIT;
                    end else if (grant != CMD_NONE) begin
                        cmd_q     <= grant;
                        cmd_addr  <= grant_addr;
                        cmd_len   <= grant_len;
                        cmd_valid <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= ST_BUSY;
                        if (cmd_q != CMD_REF) begin
                            last_grant <= cmd_q;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cmd_done) begin
                        cmd_q <= CMD_NONE;
                        state <= init_done ? ST_ARB : ST_INIT;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign cmd_type = cmd_q;

    // Data-phase strobe routed straight to the port that owns the burst.
    assign wr_ack = xfer_en && (state == ST_BUSY) && (cmd_q == CMD_WR);
    assign rd_ack = xfer_en && (state == ST_BUSY) && (cmd_q == CMD_RD);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter; the bench plays the command unit by hand.
module tb_sdram_arbiter;
    import sdram_arbiter_pkg::*;

    localparam int unsigned ADDR_W     = 21;
    localparam int unsigned LEN_W      = 9;
    localparam int unsigned REF_PERIOD = 781;

    logic              ref_clk = 1'b0;
    logic              rst = 1'b1;
    logic              init_done = 1'b0;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [LEN_W-1:0]  wr_len = '0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [LEN_W-1:0]  rd_len = '0;
    logic              wr_ack;
    logic              rd_ack;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic [CMD_W-1:0]  cmd_type;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              xfer_en = 1'b0;
    logic              cmd_done = 1'b0;
    logic [OWED_W-1:0] ref_owed;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_arbiter #(
        .REF_PERIOD (REF_PERIOD),
        .MAX_PEND   (4),
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W)
    ) dut (
        .ref_clk   (ref_clk),
        .rst       (rst),
        .init_done (init_done),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_len    (wr_len),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_len    (rd_len),
        .wr_ack    (wr_ack),
        .rd_ack    (rd_ack),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .xfer_en   (xfer_en),
        .cmd_done  (cmd_done),
        .ref_owed  (ref_owed)
    );

    always #5 ref_clk = ~ref_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge ref_clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        init_done = 1'b0;
        wr_req    = 1'b0;
        rd_req    = 1'b0;
        cmd_ready = 1'b0;
        xfer_en   = 1'b0;
        cmd_done  = 1'b0;
        tick();
        tick();
        rst       = 1'b0;
        init_done = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!cmd_valid && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, int'(cmd_valid), 1);
    endtask

    // Offer, accept, run nx data cycles, then complete one command.
    task automatic serve(input string tag, input cmd_t t, input int a, input int l,
                         input int nx, input int ew, input int er, input bit drop);
        int wc = 0;
        int rc = 0;
        wait_valid(tag, 4);
        check({tag, "_type"}, int'(cmd_type), int'(t));
        check({tag, "_addr"}, int'(cmd_addr), a);
        check({tag, "_len"},  int'(cmd_len),  l);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        if (drop) begin
            wr_req = 1'b0;
            rd_req = 1'b0;
        end
        check({tag, "_accept"}, int'(cmd_valid), 0);
        for (int i = 0; i < nx; i++) begin
            xfer_en = 1'b1;
            #1;
            if (wr_ack) wc++;
            if (rd_ack) rc++;
            tick();
        end
        xfer_en = 1'b0;
        if (nx != 0) begin
            check({tag, "_wr_ack"}, wc, ew);
            check({tag, "_rd_ack"}, rc, er);
        end
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        check({tag, "_cleared"}, int'(cmd_type), int'(CMD_NONE));
    endtask

    initial begin
        // Reset state, and no arbitration while init_done is low.
        rst     = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 21'h00100;
        wr_len  = 9'd256;
        tick();
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_type",  int'(cmd_type),  0);
        check("rst_owed",  int'(ref_owed),  0);
        check("rst_acks",  int'({wr_ack, rd_ack}), 0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("noinit_valid", int'(cmd_valid), 0);
        check("noinit_owed",  int'(ref_owed),  0);

        // Single write, with stray xfer_en/cmd_done during ISSUE ignored.
        init_done = 1'b1;
        wait_valid("wr1_pre", 4);
        xfer_en  = 1'b1;
        cmd_done = 1'b1;
        #1;
        check("stray_xfer_ack", int'(wr_ack), 0);
        tick();
        xfer_en  = 1'b0;
        cmd_done = 1'b0;
        check("stray_done_valid", int'(cmd_valid), 1);
        serve("wr1", CMD_WR, 'h100, 256, 256, 256, 0, 1'b1);
        tick();
        check("idle_valid", int'(cmd_valid), 0);

        // First refresh becomes owed exactly REF_PERIOD cycles after init.
        do_reset();
        repeat (REF_PERIOD - 1) tick();
        check("ref_owed_before", int'(ref_owed), 0);
        tick();
        check("ref_owed_after", int'(ref_owed), 1);
        check("ref_valid_lat0", int'(cmd_valid), 0);
        tick();
        check("ref_valid_lat1", int'(cmd_valid), 1);
        serve("ref1", CMD_REF, 0, 0, 0, 0, 0, 1'b0);
        check("ref_owed_served", int'(ref_owed), 0);

        // Contention: write wins the first tie, then strict alternation.
        do_reset();
        wr_addr = 21'h1AAAA;
        wr_len  = 9'd4;
        rd_addr = 21'h05555;
        rd_len  = 9'd3;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        serve("c0", CMD_WR, 'h1AAAA, 4, 4, 4, 0, 1'b0);
        serve("c1", CMD_RD, 'h05555, 3, 3, 0, 3, 1'b0);
        serve("c2", CMD_WR, 'h1AAAA, 4, 4, 4, 0, 1'b0);
        serve("c3", CMD_RD, 'h05555, 3, 3, 0, 3, 1'b1);

        // Refresh owed during a read burst beats a pending write.
        do_reset();
        rd_req  = 1'b1;
        rd_addr = 21'h00777;
        rd_len  = 9'd8;
        wait_valid("rp_rd", 4);
        check("rp_rd_type", int'(cmd_type), int'(CMD_RD));
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        rd_req    = 1'b0;
        wr_req    = 1'b1;
        wr_addr   = 21'h00042;
        wr_len    = 9'd2;
        begin
            int n = 0;
            while (ref_owed == '0 && n < 1000) begin
                tick();
                n++;
            end
        end
        check("rp_owed_busy", int'(ref_owed), 1);
        check("rp_no_preempt", int'(cmd_valid), 0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        serve("rp_ref", CMD_REF, 0, 0, 0, 0, 0, 1'b0);
        serve("rp_wr", CMD_WR, 'h42, 2, 2, 2, 0, 1'b1);

        // Saturation of owed refreshes, then four back-to-back refreshes.
        do_reset();
        wait_valid("sat_first", 1000);
        repeat (6 * REF_PERIOD) tick();
        check("sat_owed", int'(ref_owed), 4);
        check("sat_type", int'(cmd_type), int'(CMD_REF));
        for (int k = 0; k < 4; k++) begin
            serve($sformatf("sat_r%0d", k), CMD_REF, 0, 0, 0, 0, 0, 1'b0);
            check($sformatf("sat_owed%0d", k), int'(ref_owed), 3 - k);
        end
        tick();
        check("sat_idle", int'(cmd_valid), 0);

        // Zero length forced to one, then reset during the data phase.
        do_reset();
        wr_req  = 1'b1;
        wr_addr = 21'h01F00;
        wr_len  = 9'd0;
        wait_valid("z", 4);
        check("z_len", int'(cmd_len), 1);
        check("z_addr", int'(cmd_addr), 'h1F00);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        wr_req    = 1'b0;
        xfer_en   = 1'b1;
        #1;
        check("z_busy_ack", int'(wr_ack), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_ack", int'(wr_ack), 0);
        check("mid_rst_type", int'(cmd_type), 0);
        tick();
        check("mid_rst_outs", int'({cmd_valid, wr_ack, rd_ack}), 0);
        check("mid_rst_len", int'(cmd_len), 0);
        check("mid_rst_addr", int'(cmd_addr), 0);
        check("mid_rst_owed", int'(ref_owed), 0);
        xfer_en = 1'b0;
        rst     = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
